// File: rtl/proj_gfm_collector.sv
// Receive side of the extender stream: decodes one-hot parts, reassembles the packed fragment
// and restores the unsigned k-mer index. Optional PROJ_COLLECTOR_CHECK_EN adds the sticky error flag.
module proj_gfm_collector #(
    parameter int FRAG_LEN_BITS     = 256,
    parameter int FRAG_SIZE         = 128,
    parameter int KMER_SIZE         = 16,
    parameter int INDICE_LEN        = 16,
    parameter int SIGNED_INDICE_LEN = 17,
    parameter int FRAG_PART         = 16,
    parameter int FRAG_PART_ONE_HOT = 32,
    parameter int BASE_LEN          = 2,
    parameter int ONE_HOT_LEN       = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIGNED_INDICE_LEN-1:0] in_index,
    input  logic [FRAG_PART_ONE_HOT-1:0] in_gfm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FRAG_LEN_BITS-1:0]     out_fragment,
    output logic [INDICE_LEN-1:0]        out_index,
    output logic                         out_err
);

    // state   | meaning
    // COLLECT | accepting parts 0..PARTS-1 into the fragment register
    // FULL    | fragment complete, presented on out_*; only a part-0 beat may enter with the transfer

    localparam int PARTS     = FRAG_LEN_BITS / FRAG_PART;
    localparam int PART_BITS = $clog2(PARTS);
    localparam int OFFSET    = (FRAG_SIZE - KMER_SIZE) >> 1;
    localparam int BASES     = FRAG_PART / BASE_LEN;

    localparam logic [SIGNED_INDICE_LEN-1:0] OFFSET_S  = SIGNED_INDICE_LEN'(OFFSET);
    localparam logic [PART_BITS-1:0]         LAST_PART = PART_BITS'(PARTS - 1);
    localparam logic [PART_BITS-1:0]         ONE_PART  = PART_BITS'(1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic [PART_BITS-1:0]           part_cnt;
    logic [FRAG_LEN_BITS-1:0]       frag_reg;
    logic [SIGNED_INDICE_LEN-1:0]   idx_sum;
    logic [SIGNED_INDICE_LEN-1:0]   in_sum;
    logic [FRAG_PART-1:0]           dec_part;
    logic                           accept;

    function automatic logic [BASE_LEN-1:0] decode_base(input logic [ONE_HOT_LEN-1:0] oh);
        logic [BASE_LEN-1:0] code;
        case (oh)
            4'b0001: code = BASE_LEN'(0);
            4'b0010: code = BASE_LEN'(1);
            4'b0100: code = BASE_LEN'(2);
            4'b1000: code = BASE_LEN'(3);
            default: code = BASE_LEN'(0);
        endcase
        return code;
    endfunction

    always_comb begin
        dec_part = '0;
        for (int i = 0; i < BASES; i++) begin
            dec_part[i*BASE_LEN +: BASE_LEN] = decode_base(in_gfm[i*ONE_HOT_LEN +: ONE_HOT_LEN]);
        end
    end

    // Store the already re-centred index so out_index is a plain register read in FULL.
    assign in_sum = in_index + OFFSET_S;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            COLLECT: begin
                if (in_valid && (part_cnt == LAST_PART)) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            part_cnt <= '0;
            frag_reg <= '0;
            idx_sum  <= '0;
        end else if (accept) begin
            frag_reg[part_cnt*FRAG_PART +: FRAG_PART] <= dec_part;
            part_cnt <= (part_cnt == LAST_PART) ? '0 : part_cnt + ONE_PART;
            if (part_cnt == '0) begin
                idx_sum <= in_sum;
            end
        end
    end

    assign out_fragment = frag_reg;
    assign out_index    = idx_sum[INDICE_LEN-1:0];

`ifdef PROJ_COLLECTOR_CHECK_EN
    logic err_reg;
    logic beat_bad;

    function automatic logic is_one_hot(input logic [ONE_HOT_LEN-1:0] oh);
        return (oh == 4'b0001) || (oh == 4'b0010) || (oh == 4'b0100) || (oh == 4'b1000);
    endfunction

    always_comb begin
        beat_bad = 1'b0;
        for (int i = 0; i < BASES; i++) begin
            if (!is_one_hot(in_gfm[i*ONE_HOT_LEN +: ONE_HOT_LEN])) begin
                beat_bad = 1'b1;
            end
        end
    end

    // Adding OFFSET is a bijection mod 2^SIGNED_INDICE_LEN, so comparing sums equals comparing raw indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            if (part_cnt == '0) begin
                err_reg <= beat_bad | in_sum[SIGNED_INDICE_LEN-1];
            end else begin
                err_reg <= err_reg | beat_bad | (in_sum != idx_sum);
            end
        end
    end

    assign out_err = out_valid & err_reg;
`else
    logic unused_sum_msb;

    assign unused_sum_msb = idx_sum[SIGNED_INDICE_LEN-1];
    assign out_err        = 1'b0;
`endif

endmodule

// File: doc/proj_gfm_collector.md
Name: proj_gfm_collector

Overview:
- Receive side of the extender's output stream.
- Accepts one one-hot fragment part per beat plus the signed, offset-adjusted k-mer index, and decodes each one-hot base back to its 2-bit code.
- Reassembles the full packed fragment and restores the unsigned k-mer index by adding the centring offset back.
- Delivers {fragment, index} over a valid/ready output toward the fragment store / verification path.

Parameters:
- FRAG_LEN_BITS, 256: packed fragment width in bits (2 bits per base).
- FRAG_SIZE, 128: fragment length in bases.
- KMER_SIZE, 16: k-mer length in bases.
- INDICE_LEN, 16: unsigned k-mer index width.
- SIGNED_INDICE_LEN, 17: signed index width on the input stream.
- FRAG_PART, 16: packed bits per part (8 bases).
- FRAG_PART_ONE_HOT, 32: one-hot bits per part (4 per base).
- BASE_LEN, 2: bits per packed base.
- ONE_HOT_LEN, 4: bits per one-hot base.
- Derived:
  - PARTS = FRAG_LEN_BITS/FRAG_PART = 16
  - PART_BITS = clog2(PARTS)
  - OFFSET = (FRAG_SIZE-KMER_SIZE)>>1 = 56

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: input part valid.
- in_ready, output, 1: collector can accept a part.
- in_index, input, SIGNED_INDICE_LEN: signed index (k-mer index minus OFFSET).
- in_gfm, input, FRAG_PART_ONE_HOT: one-hot part, base i at [4i+:4].
- out_valid, output, 1: assembled fragment available.
- out_ready, input, 1: consumer accepts the fragment.
- out_fragment, output, FRAG_LEN_BITS: packed fragment, part k at [FRAG_PART*k +: FRAG_PART].
- out_index, output, INDICE_LEN: restored unsigned k-mer index.
- out_err, output, 1: error flag, valid with out_valid (see Optional Feature).

Behaviour:
- Handshake rules:
  - Input beat accepted when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Decode, per base: 0001->00, 0010->01, 0100->10, 1000->11. Any other pattern (zero or multi-hot) decodes to 00.
- State machine, states COLLECT and FULL:
  - COLLECT: in_ready=1, out_valid=0. Each accepted beat writes the decoded part at slot part_cnt, then part_cnt increments.
  - On the beat with part_cnt==0, in_index is captured into idx_reg.
  - When the beat with part_cnt==PARTS-1 is accepted: part_cnt wraps to 0 and the state moves to FULL.
  - FULL: out_valid=1, and out_fragment/out_index are held stable until transfer.
  - in_ready = out_ready in FULL. A part-0 beat accepted in the same cycle as the output transfer starts the next fragment with no bubble; the state returns to COLLECT.
  - FULL with no transfer: in_ready=0 and all state is held.
- Latency: out_valid rises the cycle after the last part is accepted. Steady-state throughput is one fragment per PARTS cycles.
- Index arithmetic:
  - out_index = (idx_reg + OFFSET) computed at SIGNED_INDICE_LEN width, then truncated to INDICE_LEN.
  - A negative sum is flagged only when PROJ_COLLECTOR_CHECK_EN is defined.
- The fragment register is overwritten part-by-part. No clearing between fragments is required, because every slot is rewritten before FULL.
- Reset values:
  - part_cnt=0, state=COLLECT.
  - out_valid=0, in_ready=1.
  - out_fragment=0, out_index=0, out_err=0.
- Reset mid-fragment discards the partial fragment; collection restarts at part 0.
- in_valid=0 stalls collection without losing any state.

Optional Feature:
- Macro: PROJ_COLLECTOR_CHECK_EN.
- When defined, a sticky per-fragment error bit is set if any of the following occurs:
  - any input base is not exactly one-hot;
  - in_index on parts 1..PARTS-1 differs from idx_reg;
  - idx_reg+OFFSET is negative.
- The error bit is cleared when part 0 of the next fragment is accepted, and is presented on out_err while out_valid.
- When undefined, out_err is tied to 0, no compare/check logic is built, and later-part in_index is ignored.

Test Plan:
- Reset, then 16 beats with in_gfm=all 0001, in_index=-56, out_ready=1 -> out_valid pulses one cycle after beat 16; out_fragment=0, out_index=0, out_err=0.
- 16 beats with part k holding base pattern 0010 everywhere (code 01), in_index=44 -> out_fragment=all 0x5555, out_index=100.
- Stall test: out_ready=0 after FULL with in_valid held high -> in_ready=0 and outputs stable for 5 cycles. Then out_ready=1 with a part-0 beat present -> transfer and new-fragment start occur in the same cycle.
- Assert rst after 7 accepted parts, then send a full 16-part fragment with index 0 -> output reflects only the post-reset fragment, out_index=56.
- PROJ_COLLECTOR_CHECK_EN: insert base 0011 in part 3 -> out_err=1. The next clean fragment gives out_err=0. in_index=-57 -> out_err=1.
- Random in_valid gaps (about 30% idle) over 50 fragments -> scoreboard match of fragment/index against the extender encoding model.
